// File: rtl/reg_arbiter_pkg.sv
// Shared state encodings and constants for reg_arbiter and its round-robin picker.
package reg_arbiter_pkg;

   localparam logic ON       = 1'b1;
   localparam logic OFF      = 1'b0;
   localparam int   BIT_DATA = 8;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/reg_arbiter_rr_pick2.sv
// Two-way round-robin picker, purely combinational; ptr names the requester favoured on a tie.
module rr_pick2
   import reg_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] win,
   output logic       any
);

   always_comb begin
      any = |req;
      win = {OFF, OFF};
      if (req == 2'b11) begin
         win = ptr ? 2'b10 : 2'b01;
      end else begin
         win = req;
      end
   end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin sharing of a single-port register file between two requesters; gnt 1 cycle after req, rvalid 3.
// Losers simply keep req high until granted; optional ARB_ZERO_REG_EN makes address 0 a hard zero register.
module reg_arbiter
   import reg_arbiter_pkg::*;
#(
   parameter int BIT = BIT_DATA,
   parameter int SZB = 4
)(
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [1:0]       wr,
   input  logic [2*SZB-1:0] addr,
   input  logic [2*BIT-1:0] wdata,
   output logic [1:0]       gnt,
   output logic [1:0]       rvalid,
   output logic [BIT-1:0]   rdata,
   output logic             rf_we,
   output logic [SZB-1:0]   rf_addr,
   output logic [BIT-1:0]   rf_din,
   input  logic [BIT-1:0]   rf_dout
);

   arb_state_e     state_q, state_d;
   logic           ptr_q, ptr_d;
   logic [1:0]     win_q, win_d;
   logic           is_wr_q, is_wr_d;
   logic [1:0]     gnt_q, gnt_d;
   logic [1:0]     rvalid_q, rvalid_d;
   logic [BIT-1:0] rdata_q, rdata_d;
   logic           rf_we_q, rf_we_d;
   logic [SZB-1:0] rf_addr_q, rf_addr_d;
   logic [BIT-1:0] rf_din_q, rf_din_d;

   logic [1:0]     pick_win;
   logic           pick_any;
   logic           sel_idx;
   logic           sel_wr;
   logic [SZB-1:0] sel_addr;
   logic [BIT-1:0] sel_din;
   logic           sel_zero;
   logic           rd_zero;
   logic           can_grant;

   rr_pick2 u_pick (
      .req (req),
      .ptr (ptr_q),
      .win (pick_win),
      .any (pick_any)
   );

   assign sel_idx  = pick_win[1];
   assign sel_wr   = sel_idx ? wr[1] : wr[0];
   assign sel_addr = sel_idx ? addr[2*SZB-1:SZB] : addr[SZB-1:0];
   assign sel_din  = sel_idx ? wdata[2*BIT-1:BIT] : wdata[BIT-1:0];

`ifdef ARB_ZERO_REG_EN
   assign sel_zero = (sel_addr == '0);
   assign rd_zero  = (rf_addr_q == '0);
`else
   assign sel_zero = OFF;
   assign rd_zero  = OFF;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      is_wr_d   = is_wr_q;
      gnt_d     = 2'b00;
      rvalid_d  = 2'b00;
      rdata_d   = rdata_q;
      rf_we_d   = OFF;
      rf_addr_d = rf_addr_q;
      rf_din_d  = rf_din_q;
      can_grant = OFF;

      case (state_q)
         ARB_IDLE: begin
            can_grant = ON;
         end
         ARB_ACCESS: begin
            state_d = is_wr_q ? ARB_IDLE : ARB_RESP;
         end
         ARB_RESP: begin
            rdata_d   = rd_zero ? '0 : rf_dout;
            rvalid_d  = win_q;
            state_d   = ARB_IDLE;
            // rf_dout was captured this cycle, so the port is free for the next grant
            can_grant = ON;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      if (can_grant && pick_any) begin
         state_d   = ARB_ACCESS;
         win_d     = pick_win;
         gnt_d     = pick_win;
         ptr_d     = ~sel_idx;
         is_wr_d   = sel_wr;
         rf_we_d   = sel_wr & ~sel_zero;
         rf_addr_d = sel_addr;
         rf_din_d  = sel_din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ARB_IDLE;
         ptr_q     <= 1'b0;
         win_q     <= 2'b00;
         is_wr_q   <= 1'b0;
         gnt_q     <= 2'b00;
         rvalid_q  <= 2'b00;
         rdata_q   <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_din_q  <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         is_wr_q   <= is_wr_d;
         gnt_q     <= gnt_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_din_q  <= rf_din_d;
      end
   end

   assign gnt     = gnt_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rf_we   = rf_we_q;
   assign rf_addr = rf_addr_q;
   assign rf_din  = rf_din_q;

endmodule
